add_sub_seq: RTL and testbench
==============================

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, bits processed per clock cycle.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  request; accepted only while busy=0.
REQ-006 The block SHALL have port sub_add_sel  input  1  0 = a+b, 1 = a-b; sampled at acceptance.
REQ-007 The block SHALL have ports a and b  input  WIDTH  operands, sampled at acceptance.
REQ-008 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port out_add_sub  output  WIDTH  result, registered.
REQ-011 The block SHALL have port cout  output  1  carry out of the MSB, registered.
REQ-012 The block SHALL have port ovf  output  1  signed overflow flag, registered (see Configuration).

Function
REQ-013 The block SHALL require WIDTH % CHUNK == 0 and CHUNK >= 1; N = WIDTH/CHUNK.
REQ-014 The block SHALL use the FSM states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 at an edge SHALL latch a, b and sub_add_sel, clear the chunk counter, set carry-in to sub_add_sel, and enter RUN.
REQ-016 In RUN, each edge SHALL compute one CHUNK-bit slice, LSB slice first, as a + (b XOR {WIDTH{sub_add_sel}}) + sub_add_sel, with the carry held in a register between slices.
REQ-017 The edge that processes slice N-1 SHALL update out_add_sub, cout and ovf, and SHALL enter DONE.
REQ-018 done SHALL be high for exactly the cycle in DONE, i.e. N edges after the accepting edge; CHUNK == WIDTH gives 1-cycle latency.
REQ-019 busy SHALL be 1 exactly while in RUN.
REQ-020 DONE without start SHALL return to IDLE on the next edge.
REQ-021 DONE with start SHALL begin a new operation with no bubble (back-to-back).
REQ-022 start while busy=1 SHALL be ignored: no queueing, and latched operands are unchanged.
REQ-023 Changes to a, b or sub_add_sel during RUN SHALL have no effect on the result.
REQ-024 For subtraction, cout SHALL be 1 when a >= b unsigned (no borrow) and 0 otherwise.
REQ-025 out_add_sub, cout and ovf SHALL hold their last values until the next completion; partial results SHALL never appear on the outputs.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE and set busy=0, done=0, out_add_sub=0, cout=0, ovf=0, and clear the carry and counter registers.
REQ-027 rst SHALL abort an operation in progress, with no done pulse; rst takes priority over start at the same edge.

Configuration
REQ-028 With ADD_SUB_SEQ_OVF_EN defined, ovf SHALL equal (carry into MSB) XOR (carry out of MSB) of the final slice.
REQ-029 Without ADD_SUB_SEQ_OVF_EN defined, ovf SHALL be constant 0 and the overflow logic SHALL be absent.

Verification (WIDTH=32, CHUNK=8, ADD_SUB_SEQ_OVF_EN defined)
REQ-030 Add: start with a=23456, b=12345, sub_add_sel=0 -> done exactly 4 edges later, out_add_sub=35801, cout=0, ovf=0.
REQ-031 Subtract: a=23456, b=12345, sub_add_sel=1 -> out_add_sub=11111, cout=1; then, back-to-back in the DONE cycle, a=12345, b=23456, sub_add_sel=1 -> out_add_sub=0xFFFFD499, cout=0, done 4 edges later.
REQ-032 Flags: a=0x7FFFFFFF, b=1, add -> 0x80000000, cout=0, ovf=1; a=0xFFFFFFFF, b=1, add -> 0x00000000, cout=1, ovf=0.
REQ-033 Busy and input-change behaviour: start pulsed and a changed during RUN of a=45728, b=12345, sub_add_sel=1 -> single done pulse, out_add_sub=33383, cout=1.
REQ-034 Reset mid-operation: rst asserted on edge 2 of RUN -> no done pulse, all outputs 0, next start completes normally.

Source files
------------

// File: rtl/add_sub_seq.sv
// Sequential adder/subtractor: a WIDTH-bit a+b or a-b computed CHUNK bits per clock, LSB slice first.
// Define ADD_SUB_SEQ_OVF_EN to build the signed-overflow flag; without it ovf is tied to 0.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one slice per edge, carry held in carry_q between slices
// DONE  | result just published, done pulse; start here chains the next operation
module add_sub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub_add_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_add_sub,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("add_sub_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sel_q, sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] result_next;
    logic             last_slice;

    // Operands shift right each slice so the active slice is always the low CHUNK bits;
    // the result shifts in from the top and is complete after N slices.
    assign a_slice     = a_q[CHUNK-1:0];
    assign b_slice     = b_q[CHUNK-1:0] ^ {CHUNK{sel_q}};
    assign slice_sum   = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    assign result_next = (acc_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign last_slice  = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sel_d   = sub_add_sel;
                    cnt_d   = '0;
                    carry_d = sub_add_sel;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_sum[CHUNK];
                acc_d   = result_next;
                if (last_slice) begin
                    out_d   = result_next;
                    cout_d  = slice_sum[CHUNK];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
        end
    end

`ifdef ADD_SUB_SEQ_OVF_EN
    logic ovf_q, ovf_d;
    logic msb_carry_in;

    // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
    assign msb_carry_in = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ slice_sum[CHUNK-1];

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && last_slice) begin
            ovf_d = msb_carry_in ^ slice_sum[CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign out_add_sub = out_q;
    assign cout        = cout_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Self-checking bench for add_sub_seq (WIDTH=32, CHUNK=8): arithmetic reference model plus directed vectors.
module tb_add_sub_seq;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

`ifdef ADD_SUB_SEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_add_sub;
    logic             cout;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    add_sub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .sub_add_sel(sel),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .out_add_sub(out_add_sub),
        .cout(cout),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation is in flight for N edges after acceptance; results by plain arithmetic.
    int               cyc = 0;
    int               m_fin = 0;
    bit               m_busy = 1'b0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_a, m_b;
    bit               m_sel;
    logic [WIDTH-1:0] m_out = '0;
    bit               m_cout = 1'b0;
    bit               m_ovf = 1'b0;
    logic [WIDTH:0]   m_wide;

    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_out  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_busy) begin
            if (cyc == m_fin) begin
                if (m_sel) begin
                    m_out  = m_a - m_b;
                    m_cout = (m_a >= m_b);
                    m_ovf  = OVF_ON && (m_a[WIDTH-1] != m_b[WIDTH-1]) && (m_out[WIDTH-1] != m_a[WIDTH-1]);
                end else begin
                    m_wide = {1'b0, m_a} + {1'b0, m_b};
                    m_out  = m_wide[WIDTH-1:0];
                    m_cout = m_wide[WIDTH];
                    m_ovf  = OVF_ON && (m_a[WIDTH-1] == m_b[WIDTH-1]) && (m_out[WIDTH-1] != m_a[WIDTH-1]);
                end
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (start) begin
            m_a    = a;
            m_b    = b;
            m_sel  = sel;
            m_busy = 1'b1;
            m_fin  = cyc + N;
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_out", out_add_sub, m_out);
            check("cyc_cout", 32'(cout), 32'(m_cout));
            check("cyc_ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    task automatic launch(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
        a     = ta;
        b     = tb_v;
        sel   = ts;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
        @(negedge clk);
        launch(ta, tb_v, ts);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", out_add_sub, 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        issue(32'd23456, 32'd12345, 1'b0);
        wait_done(lat);
        check("add_lat", lat, N);
        check("add_out", out_add_sub, 32'd35801);
        check("add_cout", 32'(cout), 32'd0);
        check("add_ovf", 32'(ovf), 32'd0);

        issue(32'd23456, 32'd12345, 1'b1);
        wait_done(lat);
        check("sub_lat", lat, N);
        check("sub_out", out_add_sub, 32'd11111);
        check("sub_cout", 32'(cout), 32'd1);
        launch(32'd12345, 32'd23456, 1'b1);
        wait_done(lat);
        check("b2b_lat", lat, N);
        check("b2b_out", out_add_sub, 32'hFFFFD499);
        check("b2b_cout", 32'(cout), 32'd0);

        issue(32'h7FFFFFFF, 32'd1, 1'b0);
        wait_done(lat);
        check("povf_out", out_add_sub, 32'h80000000);
        check("povf_cout", 32'(cout), 32'd0);
        check("povf_ovf", 32'(ovf), 32'(OVF_ON));

        issue(32'hFFFFFFFF, 32'd1, 1'b0);
        wait_done(lat);
        check("wrap_out", out_add_sub, 32'h00000000);
        check("wrap_cout", 32'(cout), 32'd1);
        check("wrap_ovf", 32'(ovf), 32'd0);

        issue(32'h80000000, 32'd1, 1'b1);
        wait_done(lat);
        check("novf_out", out_add_sub, 32'h7FFFFFFF);
        check("novf_ovf", 32'(ovf), 32'(OVF_ON));

        issue(32'd777, 32'd777, 1'b1);
        wait_done(lat);
        check("eq_out", out_add_sub, 32'd0);
        check("eq_cout", 32'(cout), 32'd1);

        // Start and operand changes during RUN must be ignored.
        issue(32'd45728, 32'd12345, 1'b1);
        @(negedge clk);
        a     = 32'hDEADBEEF;
        b     = 32'd5;
        sel   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 32'd1;
        wait_done(lat);
        check("ign_lat", lat, N - 2);
        check("ign_out", out_add_sub, 32'd33383);
        check("ign_cout", 32'(cout), 32'd1);
        count_pulses(6, pulses);
        check("ign_pulses", pulses, 0);

        // Reset on the second RUN edge aborts with no done pulse.
        issue(32'd1000, 32'd1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", out_add_sub, 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        count_pulses(8, pulses);
        check("abort_pulses", pulses, 0);

        issue(32'd100, 32'd58, 1'b1);
        wait_done(lat);
        check("post_lat", lat, N);
        check("post_out", out_add_sub, 32'd42);
        check("post_cout", 32'(cout), 32'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
